rr_arbiter_n: RTL

//  N-requester round-robin arbiter with a bounded time-slice (quantum) per grant.

---
 rtl/rr_arbiter_n.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-requester round-robin arbiter with a bounded time slice.
//
// The current owner keeps the grant for as long as it requests. Once it has
// held the grant for QUANTUM consecutive cycles, it must hand over at the next
// edge where another requester is pending. The next owner is always the first
// requester after the previous owner in circular order, so every requester is
// served in turn.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high; drops any grant on that edge
//   req          in   [N_REQ-1:0] level-sensitive request per requester
//   grant        out  [N_REQ-1:0] registered one-hot grant, all-zero when idle
//   grant_valid  out  |grant
//   grant_id     out  [IDW-1:0] index of the current owner, 0 when idle
//   switch_p     out  one-cycle pulse in the first cycle of every new grant
//
// Handshake: req[i] is sampled on every rising edge. grant[i] high in a cycle
// means requester i owns the resource for that cycle. grant[i] can only be
// high if req[i] was high at the previous edge. After req[i] falls, grant[i]
// stays high for exactly one more cycle.

module rr_arbiter_n #(
    parameter int N_REQ   = 4,
    parameter int QUANTUM = 8,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [IDW-1:0]   grant_id,
    output logic             switch_p
);

    localparam int CW = $clog2(QUANTUM + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [IDW-1:0]   last_q;
    logic [CW-1:0]    cnt_q;
    logic             switch_q;

    logic [IDW-1:0]   owner;
    logic             any_req;
    logic             others_req;

    // Return the first requester found when scanning p+1, p+2, ... in
    // circular order. The scan ends at p itself.
    function automatic logic [IDW-1:0] pick(input logic [N_REQ-1:0] r,
                                            input logic [IDW-1:0]   p);
        logic [IDW-1:0] res;
        logic           found;
        int             idx;
        res   = p;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(p) + k) % N_REQ;
            if (!found && r[idx]) begin
                found = 1'b1;
                res   = IDW'(idx);
            end
        end
        return res;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] i);
        logic [N_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Decode the owner index from the one-hot grant. The result is 0 when idle.
    always_comb begin
        owner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner = IDW'(i);
            end
        end
    end

    assign any_req    = |req;
    assign others_req = |(req & ~grant_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            last_q   <= IDW'(N_REQ - 1);
            cnt_q    <= '0;
            switch_q <= 1'b0;
        end else begin
            switch_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q  <= onehot(pick(req, last_q));
                        cnt_q    <= CW'(QUANTUM - 1);
                        switch_q <= 1'b1;
                        state_q  <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (!req[owner]) begin
                        // The owner has released. Hand over to the next
                        // requester in the same cycle, with no idle bubble.
                        last_q <= owner;
                        if (any_req) begin
                            grant_q  <= onehot(pick(req, owner));
                            cnt_q    <= CW'(QUANTUM - 1);
                            switch_q <= 1'b1;
                        end else begin
                            grant_q <= '0;
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (others_req) begin
                        // The quantum has expired and a competitor is waiting.
                        grant_q  <= onehot(pick(req, owner));
                        cnt_q    <= CW'(QUANTUM - 1);
                        last_q   <= owner;
                        switch_q <= 1'b1;
                    end
                    // If no competitor is waiting, cnt_q stays at 0. A
                    // competitor that appears later then preempts on its
                    // first sampled edge.
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = owner;
    assign switch_p    = switch_q;

endmodule
